// File: rtl/mux_21_pkg.sv
// mux_21 shared definitions.
// Select encodings for the 2:1 datapath selector.
package mux_21_pkg;
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;
endpackage

// File: rtl/mux_21_if.sv
// mux_21 data bus: enable, operands, select and result.
// master drives operands; slave (the mux) drives results.
interface mux_21_if #(
  parameter int WIDTH = 1
) ();
  logic             en;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             s;
  logic [WIDTH-1:0] out;
  logic             out_valid;

  modport master (
    output en, a, b, s,
    input  out, out_valid
  );

  modport slave (
    input  en, a, b, s,
    output out, out_valid
  );
endinterface

// File: rtl/mux_21_core.sv
// mux_21 core: combinational WIDTH-wide 2:1 select.
// An unknown select propagates X in simulation.
module mux_21_core
  import mux_21_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = 'x;
    case (s)
      SEL_A:   y = a;
      SEL_B:   y = b;
      default: y = 'x;
    endcase
  end

endmodule

// File: rtl/mux_21.sv
// mux_21 top: 2:1 selector with optional output register.
// REG_OUT=1 adds a 1-cycle capture stage with a valid flag.
module mux_21
  import mux_21_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1'b1
) (
  input  logic      clk,
  input  logic      rst_n,
  mux_21_if.slave   bus
);

  logic [WIDTH-1:0] sel;

  mux_21_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a (bus.a),
    .b (bus.b),
    .s (bus.s),
    .y (sel)
  );

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] out_q;
    logic             out_valid_d;
    logic             out_valid_q;

    always_comb begin
      out_d       = out_q;
      out_valid_d = 1'b0;
      if (bus.en) begin
        out_d       = sel;
        out_valid_d = 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_q       <= '0;
        out_valid_q <= 1'b0;
      end else begin
        out_q       <= out_d;
        out_valid_q <= out_valid_d;
      end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
  end else begin : g_comb
    // clk/rst_n have no function in the combinational variant
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    assign bus.out       = sel;
    assign bus.out_valid = bus.en;
  end

endmodule

// File: tb/tb_mux_21.sv
// mux_21 bench: registered 1-bit, registered 8-bit
// and combinational 1-bit instances, directed vectors.
module tb_mux_21;

  logic clk;
  logic rst_n;
  int   n_run;
  int   n_fail;

  mux_21_if #(.WIDTH(1)) if1 ();
  mux_21_if #(.WIDTH(8)) if8 ();
  mux_21_if #(.WIDTH(1)) if0 ();

  mux_21 #(.WIDTH(1), .REG_OUT(1'b1)) u_r1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  mux_21 #(.WIDTH(8), .REG_OUT(1'b1)) u_r8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8.slave)
  );

  mux_21 #(.WIDTH(1), .REG_OUT(1'b0)) u_c1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] tt_exp;
  logic [2:0] v;
  logic [7:0] alt;

  initial begin
    n_run  = 0;
    n_fail = 0;
    tt_exp = 8'b1101_1000;

    rst_n = 1'b0;
    if1.en = 1'b0; if1.a = 1'b0;
    if1.b = 1'b0;  if1.s = 1'b0;
    if8.en = 1'b0; if8.a = 8'h00;
    if8.b = 8'h00; if8.s = 1'b0;
    if0.en = 1'b0; if0.a = 1'b1;
    if0.b = 1'b0;  if0.s = 1'b0;

    #100;
    chk("rst_out1", 32'(if1.out), 32'h0);
    chk("rst_vld1", 32'(if1.out_valid), 32'h0);
    chk("rst_out8", 32'(if8.out), 32'h0);
    chk("rst_vld8", 32'(if8.out_valid), 32'h0);
    chk("comb_in_rst", 32'(if0.out), 32'h1);

    rst_n  = 1'b1;
    if1.en = 1'b1;
    step();
    chk("pu_out", 32'(if1.out), 32'h0);
    chk("pu_vld", 32'(if1.out_valid), 32'h1);

    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      {if1.a, if1.b, if1.s} = v;
      step();
      chk($sformatf("tt%0d", i),
          32'(if1.out), 32'(tt_exp[i]));
      chk($sformatf("tt_vld%0d", i),
          32'(if1.out_valid), 32'h1);
    end

    if8.en = 1'b1;
    if8.a  = 8'hA5;
    if8.b  = 8'h3C;
    if8.s  = 1'b0;
    step();
    chk("w8_s0", 32'(if8.out), 32'hA5);
    if8.s = 1'b1;
    step();
    chk("w8_s1", 32'(if8.out), 32'h3C);

    alt = 8'h3C;
    for (int i = 0; i < 4; i++) begin
      if8.s = ~if8.s;
      #1;
      chk($sformatf("w8_lag%0d", i),
          32'(if8.out), 32'(alt));
      alt = (alt == 8'h3C) ? 8'hA5 : 8'h3C;
      step();
      chk($sformatf("w8_tog%0d", i),
          32'(if8.out), 32'(alt));
    end

    if1.a = 1'b1; if1.b = 1'b0; if1.s = 1'b0;
    step();
    chk("hold_cap", 32'(if1.out), 32'h1);
    if1.en = 1'b0; if1.a = 1'b0; if1.s = 1'b1;
    if8.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("hold_out%0d", i),
          32'(if1.out), 32'h1);
      chk($sformatf("hold_vld%0d", i),
          32'(if1.out_valid), 32'h0);
    end

    chk("pre_rst8", 32'(if8.out), 32'h3C);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out8", 32'(if8.out), 32'h0);
    chk("arst_vld8", 32'(if8.out_valid), 32'h0);
    chk("arst_out1", 32'(if1.out), 32'h0);

    step();
    rst_n  = 1'b1;
    if8.s  = 1'b0;
    step();
    chk("post_rst_hold", 32'(if8.out), 32'h0);
    if8.en = 1'b1;
    step();
    chk("post_rst_cap", 32'(if8.out), 32'hA5);
    chk("post_rst_vld", 32'(if8.out_valid), 32'h1);

    if0.en = 1'b0;
    if0.a = 1'b1; if0.b = 1'b0; if0.s = 1'b0;
    #1;
    chk("comb_s0", 32'(if0.out), 32'h1);
    chk("comb_vld0", 32'(if0.out_valid), 32'h0);
    if0.s = 1'b1;
    #1;
    chk("comb_s1", 32'(if0.out), 32'h0);
    if0.en = 1'b1;
    #1;
    chk("comb_vld1", 32'(if0.out_valid), 32'h1);
    if0.s = 1'b0;
    #1;
    chk("comb_s0b", 32'(if0.out), 32'h1);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
